// File: rtl/freelist_ctrl_8r16w_pkg.sv
// Shared constants and types for the physical-tag free-list controller.
// The top-level parameters default to these values.
package freelist_ctrl_8r16w_pkg;

  localparam int FL_DEPTH    = 16;
  localparam int FL_INDEX    = 4;
  localparam int FL_RD_PORTS = 8;
  localparam int FL_WR_PORTS = 16;

  typedef logic [FL_INDEX-1:0] fl_ptr_t;
  typedef logic [FL_INDEX:0]   fl_cnt_t;

endpackage

// File: rtl/freelist_ctrl_8r16w_prefix_count16.sv
// Exclusive prefix popcount of a push mask plus its total popcount.
// Prefix j counts the set bits below j, so it never exceeds WIDTH-1.
module freelist_ctrl_8r16w_prefix_count16 #(
  parameter int WIDTH = 16,
  parameter int PW    = 4,
  parameter int TW    = 5
) (
  input  logic [WIDTH-1:0]    mask_i,
  output logic [WIDTH*PW-1:0] prefix_o,
  output logic [TW-1:0]       total_o
);

  logic [TW-1:0] acc;

  always_comb begin
    acc      = '0;
    prefix_o = '0;
    for (int j = 0; j < WIDTH; j++) begin
      prefix_o[j*PW +: PW] = PW'(acc);
      acc                  = acc + TW'(mask_i[j]);
    end
    total_o = acc;
  end

endmodule

// File: rtl/freelist_ctrl_8r16w.sv
// Free-list FIFO controller: owns head/tail/count and drives the read and
// compacted write addresses of the 8R/16W SRAM. No data path here.
module freelist_ctrl_8r16w
  import freelist_ctrl_8r16w_pkg::*;
#(
  parameter int DEPTH    = FL_DEPTH,
  parameter int INDEX    = FL_INDEX,
  parameter int RD_PORTS = FL_RD_PORTS,
  parameter int WR_PORTS = FL_WR_PORTS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush_i,
  input  logic [3:0]                pop_req_i,
  input  logic [WR_PORTS-1:0]       push_valid_i,
  output logic [RD_PORTS*INDEX-1:0] rd_addr_o,
  output logic                      pop_grant_o,
  output logic                      stall_o,
  output logic [WR_PORTS*INDEX-1:0] wr_addr_o,
  output logic [WR_PORTS-1:0]       we_o,
  output logic                      push_ready_o,
  output logic [INDEX:0]            count_o,
  output logic                      empty_o,
  output logic                      full_o
);

  // Two extra bits let count + pushes - pops be formed without wrapping.
  localparam int            CW      = INDEX + 2;
  localparam logic [3:0]    RD_MAX  = 4'(RD_PORTS);
  localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);
  localparam logic [INDEX:0] DEPTH_C = (INDEX+1)'(DEPTH);

  logic [INDEX-1:0]          head;
  logic [INDEX-1:0]          tail;
  logic [INDEX:0]            count;
  logic [WR_PORTS*INDEX-1:0] prefix;
  logic [INDEX:0]            push_total;
  logic [CW-1:0]             pop_n;
  logic [CW-1:0]             push_n;
  logic [CW-1:0]             cnt_ext;
  logic [CW-1:0]             count_next;

  function automatic logic [CW-1:0] sat_pop(input logic [3:0] req);
    if (req > RD_MAX) return CW'(RD_PORTS);
    else              return CW'(req);
  endfunction

  freelist_ctrl_8r16w_prefix_count16 #(
    .WIDTH (WR_PORTS),
    .PW    (INDEX),
    .TW    (INDEX + 1)
  ) u_prefix_count16 (
    .mask_i   (push_valid_i),
    .prefix_o (prefix),
    .total_o  (push_total)
  );

  assign pop_n   = sat_pop(pop_req_i);
  assign push_n  = CW'(push_total);
  assign cnt_ext = CW'(count);

  // Space is judged on the start-of-cycle count; same-cycle pops free nothing.
  assign stall_o      = pop_n > cnt_ext;
  assign pop_grant_o  = !reset && !flush_i && (pop_n != '0) && (pop_n <= cnt_ext);
  assign push_ready_o = !reset && !flush_i && (push_n <= (DEPTH_W - cnt_ext));

  assign count_next = cnt_ext + (push_ready_o ? push_n : '0) - (pop_grant_o ? pop_n : '0);

  always_comb begin
    rd_addr_o = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      rd_addr_o[k*INDEX +: INDEX] = head + INDEX'(k);
    end
  end

  // Valid producers are packed onto consecutive slots starting at tail.
  always_comb begin
    we_o      = '0;
    wr_addr_o = '0;
    for (int j = 0; j < WR_PORTS; j++) begin
      we_o[j]                     = push_ready_o & push_valid_i[j];
      wr_addr_o[j*INDEX +: INDEX] = we_o[j] ? (tail + prefix[j*INDEX +: INDEX]) : tail;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (pop_grant_o)  head <= head + INDEX'(pop_n);
      if (push_ready_o) tail <= tail + INDEX'(push_total);
      count <= count_next[INDEX:0];
    end
  end

  assign count_o = count;
  assign empty_o = (count == '0);
  assign full_o  = (count == DEPTH_C);

`ifndef SYNTHESIS
  count_range_a: assert property (@(posedge clk) disable iff (reset)
    flush_i || (count_next <= DEPTH_W));
`endif

endmodule

// File: tb/tb_freelist_ctrl_8r16w.sv
// Bench for the free-list controller: directed vector table, hand-written
// wrap/reset sequences and randomized traffic against an occupancy model.
module tb_freelist_ctrl_8r16w;
  import freelist_ctrl_8r16w_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush_i = 1'b0;
  logic [3:0]  pop_req_i = '0;
  logic [15:0] push_valid_i = '0;
  logic [31:0] rd_addr_o;
  logic        pop_grant_o;
  logic        stall_o;
  logic [63:0] wr_addr_o;
  logic [15:0] we_o;
  logic        push_ready_o;
  fl_cnt_t     count_o;
  logic        empty_o;
  logic        full_o;

  freelist_ctrl_8r16w dut (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush_i),
    .pop_req_i    (pop_req_i),
    .push_valid_i (push_valid_i),
    .rd_addr_o    (rd_addr_o),
    .pop_grant_o  (pop_grant_o),
    .stall_o      (stall_o),
    .wr_addr_o    (wr_addr_o),
    .we_o         (we_o),
    .push_ready_o (push_ready_o),
    .count_o      (count_o),
    .empty_o      (empty_o),
    .full_o       (full_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: oldest free entry position and number of free entries held.
  int m_head = 0;
  int m_cnt  = 0;

  typedef struct {
    logic        flush;
    logic [3:0]  pop;
    logic [15:0] push;
    logic        grant;
    logic        stall;
    logic        ready;
    logic [15:0] we;
    int          cnt_after;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called between edges; compares the cycle's outputs, then advances the model.
  task automatic model_step();
    int p, n, tl, seen;
    logic g, s, r;
    logic [15:0] we_e;
    logic [63:0] wa;
    logic [31:0] ra;
    p  = (int'(pop_req_i) > FL_RD_PORTS) ? FL_RD_PORTS : int'(pop_req_i);
    n  = $countones(push_valid_i);
    tl = (m_head + m_cnt) % FL_DEPTH;
    g  = !flush_i && (p != 0) && (p <= m_cnt);
    s  = (p > m_cnt);
    r  = !flush_i && (n <= FL_DEPTH - m_cnt);
    we_e = r ? push_valid_i : 16'h0;
    ra = '0;
    for (int k = 0; k < FL_RD_PORTS; k++) ra[k*4 +: 4] = 4'((m_head + k) % FL_DEPTH);
    wa = '0;
    seen = 0;
    for (int j = 0; j < FL_WR_PORTS; j++) begin
      if (we_e[j]) begin
        wa[j*4 +: 4] = 4'((tl + seen) % FL_DEPTH);
        seen++;
      end else begin
        wa[j*4 +: 4] = 4'(tl);
      end
    end
    chk("count", 64'(count_o), 64'(m_cnt));
    chk("empty", 64'(empty_o), 64'(m_cnt == 0));
    chk("full", 64'(full_o), 64'(m_cnt == FL_DEPTH));
    chk("grant", 64'(pop_grant_o), 64'(g));
    chk("stall", 64'(stall_o), 64'(s));
    chk("ready", 64'(push_ready_o), 64'(r));
    chk("we", 64'(we_o), 64'(we_e));
    chk("rd_addr", 64'(rd_addr_o), 64'(ra));
    chk("wr_addr", wr_addr_o, wa);
    @(posedge clk);
    if (flush_i) begin
      m_head = tl;
      m_cnt  = 0;
    end else begin
      if (g) begin
        m_head = (m_head + p) % FL_DEPTH;
        m_cnt  = m_cnt - p;
      end
      if (r) m_cnt = m_cnt + n;
    end
    #1;
  endtask

  task automatic drive(input logic fl, input logic [3:0] pop, input logic [15:0] push);
    flush_i      = fl;
    pop_req_i    = pop;
    push_valid_i = push;
  endtask

  // Asserts reset between edges and checks the held-in-reset outputs.
  task automatic do_reset();
    drive(1'b0, 4'd1, 16'hFFFF);
    #2 reset = 1'b1;
    #1;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd1);
    chk("rst_grant", 64'(pop_grant_o), 64'd0);
    chk("rst_ready", 64'(push_ready_o), 64'd0);
    chk("rst_we", 64'(we_o), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr_o), 64'h76543210);
    @(posedge clk);
    #1;
    chk("rst_count_held", 64'(count_o), 64'd0);
    drive(1'b0, 4'd0, 16'h0);
    reset  = 1'b0;
    m_head = 0;
    m_cnt  = 0;
  endtask

  initial begin
    tbl[0] = '{1'b0, 4'd0,  16'h8025, 1'b0, 1'b0, 1'b1, 16'h8025, 4};
    tbl[1] = '{1'b0, 4'd5,  16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 4};
    tbl[2] = '{1'b0, 4'd4,  16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 0};
    tbl[3] = '{1'b0, 4'd0,  16'hFFFF, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16};
    tbl[4] = '{1'b0, 4'd2,  16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 14};
    tbl[5] = '{1'b0, 4'd15, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 6};
    tbl[6] = '{1'b1, 4'd2,  16'h0007, 1'b0, 1'b0, 1'b0, 16'h0000, 0};
    tbl[7] = '{1'b0, 4'd1,  16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 0};

    do_reset();

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].flush, tbl[i].pop, tbl[i].push);
      @(negedge clk);
      chk($sformatf("tbl%0d_grant", i), 64'(pop_grant_o), 64'(tbl[i].grant));
      chk($sformatf("tbl%0d_stall", i), 64'(stall_o), 64'(tbl[i].stall));
      chk($sformatf("tbl%0d_ready", i), 64'(push_ready_o), 64'(tbl[i].ready));
      chk($sformatf("tbl%0d_we", i), 64'(we_o), 64'(tbl[i].we));
      if (i == 0) chk("tbl0_wr_addr", wr_addr_o, 64'h3000000000200100);
      if (i == 3) chk("tbl3_full_before", 64'(full_o), 64'd0);
      model_step();
      chk($sformatf("tbl%0d_count_after", i), 64'(count_o), 64'(tbl[i].cnt_after));
      if (i == 3) chk("tbl3_full_after", 64'(full_o), 64'd1);
    end
    drive(1'b0, 4'd0, 16'h0);
    @(negedge clk);
    chk("flush_head_eq_tail", 64'(pop_grant_o), 64'd0);
    model_step();

    // Wrap-around: bring head and tail to 14 with nothing held.
    do_reset();
    drive(1'b0, 4'd0, 16'h3FFF); @(negedge clk); model_step();
    drive(1'b0, 4'd8, 16'h0000); @(negedge clk); model_step();
    drive(1'b0, 4'd6, 16'h0000); @(negedge clk); model_step();
    chk("wrap_empty", 64'(count_o), 64'd0);
    drive(1'b0, 4'd0, 16'h000F);
    @(negedge clk);
    chk("wrap_wr_addr", wr_addr_o, 64'hEEEEEEEEEEEE10FE);
    model_step();
    drive(1'b0, 4'd3, 16'h0000);
    @(negedge clk);
    chk("wrap_grant", 64'(pop_grant_o), 64'd1);
    chk("wrap_rd_addr", 64'(rd_addr_o), 64'h543210FE);
    model_step();
    chk("wrap_count_after", 64'(count_o), 64'd1);
    chk("wrap_head_after", 64'(rd_addr_o[3:0]), 64'd1);
    drive(1'b0, 4'd0, 16'h0000);

    // Randomized traffic, with a reset dropped in the middle.
    for (int c = 0; c < 600; c++) begin
      logic [3:0]  pr;
      logic [15:0] pm;
      if (c == 300) do_reset();
      pr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
      case ($urandom_range(0, 3))
        0:       pm = 16'($urandom);
        1:       pm = 16'($urandom) & 16'($urandom) & 16'($urandom);
        2:       pm = 16'h0;
        default: pm = 16'($urandom) & 16'($urandom);
      endcase
      drive(($urandom_range(0, 31) == 0), pr, pm);
      @(negedge clk);
      model_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freelist_ctrl_8r16w.md
Name: freelist_ctrl_8r16w

Overview:
- Circular-FIFO controller that sits directly upstream of the 8-read/16-write multi-ported SRAM; together they form the physical-tag free list used by rename.
- Owns head and tail pointers and the occupancy count.
- Drives the SRAM's 8 read addresses (pop slots head..head+7) and its 16 write addresses and write enables (compacted pushes at the tail).
- Push data goes straight from producers to the SRAM data ports. This block carries no data path.

Parameters:
- DEPTH, 16, number of SRAM entries; must be a power of two.
- INDEX, 4, log2(DEPTH); pointer width.
- RD_PORTS, 8, maximum pops per cycle.
- WR_PORTS, 16, maximum pushes per cycle; must be <= DEPTH.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous empty: head<=tail, count<=0.
- pop_req_i  in  4  number of entries requested this cycle, 0..RD_PORTS; values >RD_PORTS are treated as RD_PORTS.
- push_valid_i  in  WR_PORTS  per-producer push request mask; any bit pattern allowed.
- rd_addr_o  out  RD_PORTS*INDEX  slot k = (head+k) mod DEPTH, to SRAM read port k.
- pop_grant_o  out  1  pop accepted this cycle; SRAM data0..data(pop_req-1) are valid.
- stall_o  out  1  pop_req_i > count; pop rejected.
- wr_addr_o  out  WR_PORTS*INDEX  write address for SRAM write port j.
- we_o  out  WR_PORTS  write enable for SRAM write port j.
- push_ready_o  out  1  the whole push mask is accepted this cycle.
- count_o  out  INDEX+1  registered occupancy, 0..DEPTH.
- empty_o  out  1  count==0.
- full_o  out  1  count==DEPTH.

Behaviour:
- Reset (async, active-high): head=0, tail=0, count=0.
  - Outputs during reset: count_o=0, empty_o=1, full_o=0, we_o=0, pop_grant_o=0, push_ready_o=0 (pushes gated off while reset is high).
  - stall_o = (pop_req_i != 0).
  - rd_addr_o = 0..RD_PORTS-1.
- Pop is combinational and all-or-nothing.
  - Let P = min(pop_req_i, RD_PORTS).
  - pop_grant_o = (P != 0) && (P <= count) && !flush_i.
  - stall_o = (P > count).
  - On grant, at the next edge head <= (head+P) mod DEPTH.
  - Read latency is zero: SRAM reads are combinational, so granted data is valid in the same cycle.
- Push is combinational and all-or-nothing.
  - Let N = popcount(push_valid_i).
  - push_ready_o = (N <= DEPTH-count) && !flush_i.
  - Space is judged on start-of-cycle count only; same-cycle pops do not free space for same-cycle pushes.
  - When ready, for each j: we_o[j] = push_valid_i[j] and wr_addr_o[j] = (tail + prefix_j) mod DEPTH, where prefix_j = popcount(push_valid_i[j-1:0]).
  - Invalid ports: we_o=0 and wr_addr_o = tail (don't-care, but fixed for determinism).
  - Accepted push: at the next edge tail <= (tail+N) mod DEPTH.
  - Rejected push: all we_o are 0 and no state changes.
- Count update: count_next = count + (push_ready_o ? N : 0) - (pop_grant_o ? P : 0).
  - Computed in INDEX+2 bits.
  - The result is provably in 0..DEPTH; a simulation-only assertion flags violations.
- Wrap-around:
  - All pointer arithmetic is modulo DEPTH.
  - Read slots and write slots may each straddle entry DEPTH-1 to entry 0.
- Simultaneous pop and push to the same physical slot: the pop reads the old (pre-edge) contents and the write lands at the edge. The slots cannot actually alias, because pushes only target free slots.
- Write collisions: accepted write addresses are pairwise distinct, since they are consecutive and N <= DEPTH.
- flush_i:
  - Highest synchronous priority.
  - Forces pop_grant_o=0, push_ready_o=0, we_o=0.
  - Next edge: head<=tail, count<=0.
- Reset mid-operation: asserting reset clears state immediately, independent of clk, and any in-flight push is lost. After deassertion, the first edge operates on the empty state.
- State machine: none beyond the pointer/count registers. Status outputs are decoded from the registered count.

Decomposition:
- Shared package:
  - FL_DEPTH, FL_INDEX, FL_RD_PORTS, FL_WR_PORTS constants.
  - fl_ptr_t (INDEX bits) and fl_cnt_t (INDEX+1 bits) typedefs.
- One natural sub-module: prefix_count16.
  - Takes the WR_PORTS-bit mask.
  - Produces an exclusive prefix count per bit plus the total popcount N.
  - Instanced once; pure combinational.

Test Plan:
- Reset then idle:
  - Stimulus: reset=1 asynchronously mid-cycle.
  - Required response: count_o=0, empty_o=1; with pop_req_i=1, stall_o=1 and pop_grant_o=0; rd_addr_o = {0..7}.
- Sparse push compaction:
  - Stimulus: from empty, push_valid_i=16'b1000_0000_0010_0101.
  - Required response: we_o on ports 0,2,5,15 with wr_addr_o 0,1,2,3; next cycle count_o=4, tail=4.
- Pop all-or-nothing:
  - Stimulus: count=4, pop_req_i=5.
  - Required response: stall_o=1, grant=0, head unchanged.
  - Then pop_req_i=4: grant=1, rd_addr_o slots 0..3 = 0,1,2,3; next cycle count_o=0.
- Wrap-around:
  - Stimulus: head=tail=14, count=0; push 4.
  - Required response: wr_addr_o = 14,15,0,1.
  - Next cycle pop 3: rd_addr_o = 14,15,0 with grant; then head=1, count_o=1.
- Full and overflow:
  - Stimulus: push 16 from empty.
  - Required response: full_o=1 next cycle.
  - Then push 1 with pop 2 in the same cycle: push_ready_o=0, pop granted, count_o=14.
- Flush priority:
  - Stimulus: count=6, pop_req_i=2, push 3, flush_i=1.
  - Required response: grant=0, ready=0, we_o=0; next cycle count_o=0, head==tail.
